// File: rtl/idexe_fwd.sv
// idexe_fwd: decode-side operand stage. Forwards EXE/MEM results onto the
// register file read data, detects load-use hazards (one-cycle stall with a
// bubble), and holds the ID/EXE pipeline register feeding the ALU.
module idexe_fwd #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [31:0]      qa,
  input  logic [31:0]      qb,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic             daluimm,
  input  logic [3:0]       daluc,
  input  logic [31:0]      dimm,
  input  logic [4:0]       drn,
  input  logic [31:0]      ealu,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic [31:0]      malu,
  input  logic [31:0]      mmo,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic             ealuimm,
  output logic [3:0]       ealuc,
  output logic [31:0]      ea,
  output logic [31:0]      eb,
  output logic [31:0]      eimm,
  output logic [4:0]       ern,
  output logic             wpcir,
  output logic [CNT_W-1:0] stall_cnt
);

  logic        exe_hit_a, exe_hit_b;
  logic        mem_hit_a, mem_hit_b;
  logic [31:0] mem_val;
  logic [31:0] fwd_a, fwd_b;
  logic        stall;

  // Operand forwarding: EXE result first, then MEM (memory data for loads),
  // otherwise the register file value. Register 0 is never forwarded. A load
  // in EXE has no result yet, so it is excluded here and handled by stall.
  always_comb begin
    exe_hit_a = ewreg & ~em2reg & (ern != 5'd0) & (ern == rs);
    exe_hit_b = ewreg & ~em2reg & (ern != 5'd0) & (ern == rt);
    mem_hit_a = mwreg & (mrn != 5'd0) & (mrn == rs);
    mem_hit_b = mwreg & (mrn != 5'd0) & (mrn == rt);
    mem_val   = mm2reg ? mmo : malu;
    fwd_a     = qa;
    fwd_b     = qb;
    if (exe_hit_a)      fwd_a = ealu;
    else if (mem_hit_a) fwd_a = mem_val;
    if (exe_hit_b)      fwd_b = ealu;
    else if (mem_hit_b) fwd_b = mem_val;
  end

  // Load-use hazard: the load in EXE produces data one cycle too late.
  always_comb begin
    stall = ewreg & em2reg & (ern != 5'd0) &
            ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
    wpcir = ~stall;
  end

  // ID/EXE pipeline register; a stall loads an all-zero bubble (NOP).
  always_ff @(posedge clk) begin
    if (!clrn || stall) begin
      ewreg   <= 1'b0;
      em2reg  <= 1'b0;
      ewmem   <= 1'b0;
      ealuimm <= 1'b0;
      ealuc   <= 4'd0;
      ea      <= 32'd0;
      eb      <= 32'd0;
      eimm    <= 32'd0;
      ern     <= 5'd0;
    end else begin
      ewreg   <= dwreg;
      em2reg  <= dm2reg;
      ewmem   <= dwmem;
      ealuimm <= daluimm;
      ealuc   <= daluc;
      ea      <= fwd_a;
      eb      <= fwd_b;
      eimm    <= dimm;
      ern     <= drn;
    end
  end

  // Saturating count of stall cycles since reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_idexe_fwd.sv
// Scoreboard bench for idexe_fwd: stimulus pushes expected values tagged with
// the cycle they are due; a monitor on the falling edge pops and compares.
module tb_idexe_fwd;

  localparam int CW = 4;

  localparam int S_EA = 0, S_EB = 1, S_WPCIR = 2, S_CTL = 3, S_IMM = 4,
                 S_CNT = 5, S_ALL = 6;

  logic          clk = 1'b0;
  logic          clrn;
  logic [4:0]    rs, rt, drn, mrn;
  logic          use_rs, use_rt;
  logic [31:0]   qa, qb, dimm, ealu, malu, mmo;
  logic          dwreg, dm2reg, dwmem, daluimm, mwreg, mm2reg;
  logic [3:0]    daluc;
  logic          ewreg, em2reg, ewmem, ealuimm, wpcir;
  logic [3:0]    ealuc;
  logic [31:0]   ea, eb, eimm;
  logic [4:0]    ern;
  logic [CW-1:0] stall_cnt;

  typedef struct {
    int          due;
    int          sig;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  idexe_fwd #(.CNT_W(CW)) dut (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .qa(qa), .qb(qb), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
    .daluimm(daluimm), .daluc(daluc), .dimm(dimm), .drn(drn), .ealu(ealu),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
    .ealuc(ealuc), .ea(ea), .eb(eb), .eimm(eimm), .ern(ern), .wpcir(wpcir),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Count rising edges so expectations can name the cycle they are due in.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(int sig);
    case (sig)
      S_EA:    return {32'd0, ea};
      S_EB:    return {32'd0, eb};
      S_WPCIR: return {63'd0, wpcir};
      S_CTL:   return {51'd0, ewreg, em2reg, ewmem, ealuimm, ealuc, ern};
      S_IMM:   return {32'd0, eimm};
      S_CNT:   return {60'd0, stall_cnt};
      default: return {63'd0, |{ewreg, em2reg, ewmem, ealuimm, ealuc, ea, eb, eimm, ern}};
    endcase
  endfunction

  // Monitor: compare every expectation that has come due this cycle.
  always @(negedge clk) begin
    chk_t c;
    logic [63:0] a;
    while (q.size() > 0 && q[0].due <= cyc) begin
      c = q.pop_front();
      a = actual(c.sig);
      n_chk++;
      if (a !== c.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %h expected %h", c.name, cyc, a, c.exp);
      end
    end
  end

  task automatic expect_at(input int due, input int sig, input logic [63:0] exp,
                           input string name);
    chk_t c;
    c.due = due; c.sig = sig; c.exp = exp; c.name = name;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs = 0; rt = 0; use_rs = 0; use_rt = 0; qa = 0; qb = 0;
    dwreg = 0; dm2reg = 0; dwmem = 0; daluimm = 0; daluc = 0; dimm = 0; drn = 0;
    ealu = 0; mwreg = 0; mm2reg = 0; mrn = 0; malu = 0; mmo = 0;
  endtask

  task automatic rand_in();
    rs = 5'($urandom); rt = 5'($urandom); use_rs = 1'($urandom); use_rt = 1'($urandom);
    qa = $urandom; qb = $urandom; dwreg = 1'($urandom); dm2reg = 1'($urandom);
    dwmem = 1'($urandom); daluimm = 1'($urandom); daluc = 4'($urandom);
    dimm = $urandom; drn = 5'($urandom); ealu = $urandom; mwreg = 1'($urandom);
    mm2reg = 1'($urandom); mrn = 5'($urandom); malu = $urandom; mmo = $urandom;
  endtask

  initial begin
    clrn = 1'b0;
    rand_in();
    expect_at(2, S_ALL, 64'd0, "reset_outputs");
    expect_at(2, S_CNT, 64'd0, "reset_cnt");
    expect_at(2, S_WPCIR, 64'd1, "reset_wpcir");
    tick();
    rand_in();
    tick();

    // cyc 2: load an ALU producer of r5 with distinctive side controls
    clrn = 1'b1;
    clear_in();
    dwreg = 1; dwmem = 1; daluimm = 1; daluc = 4'hA; dimm = 32'h0000_BEEF; drn = 5;
    expect_at(3, S_CTL, {51'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 5'd5}, "ctl_load");
    expect_at(3, S_IMM, 64'h0000_BEEF, "imm_load");
    tick();

    // cyc 3: consumer of r5 takes the EXE result
    clear_in();
    rs = 5; use_rs = 1; qa = 32'hDEAD_BEEF; ealu = 32'h1234_5678;
    expect_at(3, S_WPCIR, 64'd1, "alu_no_stall");
    expect_at(4, S_EA, 64'h1234_5678, "exe_fwd");
    tick();

    // cyc 4: producer writing r0
    clear_in();
    dwreg = 1; drn = 0;
    tick();

    // cyc 5: r0 must never be forwarded
    clear_in();
    rs = 0; use_rs = 1; qa = 0; ealu = 32'h1234_5678;
    expect_at(6, S_EA, 64'd0, "exe_fwd_r0");
    tick();

    // cyc 6/7: MEM forward from ALU result, then from memory data
    clear_in();
    mwreg = 1; mrn = 7; rt = 7; use_rt = 1; malu = 32'h11; mmo = 32'h22; qb = 32'hFFFF_0000;
    expect_at(7, S_EB, 64'h11, "mem_fwd_alu");
    tick();
    mm2reg = 1; dwreg = 1; drn = 7;
    expect_at(8, S_EB, 64'h22, "mem_fwd_mo");
    tick();

    // cyc 8: EXE and MEM both hit r7; EXE wins
    ealu = 32'h33; dwreg = 0; drn = 0;
    expect_at(9, S_EB, 64'h33, "exe_priority");
    tick();

    // cyc 9: load into r3
    clear_in();
    dwreg = 1; dm2reg = 1; drn = 3;
    tick();

    // cyc 10: dependent instruction stalls, bubble enters EXE
    clear_in();
    rs = 3; use_rs = 1; qa = 32'h1111; dwreg = 1; drn = 9;
    expect_at(10, S_WPCIR, 64'd0, "lu_stall");
    expect_at(11, S_CTL, 64'd0, "lu_bubble");
    expect_at(11, S_CNT, 64'd1, "lu_cnt");
    tick();

    // cyc 11: load now in MEM, data forwarded from mmo
    mwreg = 1; mrn = 3; mm2reg = 1; mmo = 32'hCAFE;
    expect_at(11, S_WPCIR, 64'd1, "lu_one_cycle");
    expect_at(12, S_EA, 64'hCAFE, "lu_mem_fwd");
    expect_at(12, S_CNT, 64'd1, "lu_cnt_hold");
    tick();

    // cyc 12/13: same load-use pair but rs unused -> no stall
    clear_in();
    dwreg = 1; dm2reg = 1; drn = 3;
    tick();
    clear_in();
    rs = 3; use_rs = 0; rt = 4; qa = 32'h5555; dwreg = 1; drn = 10;
    expect_at(13, S_WPCIR, 64'd1, "unused_rs_no_stall");
    expect_at(14, S_CTL, {51'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd10}, "unused_rs_load");
    expect_at(14, S_EA, 64'h5555, "unused_rs_qa");
    expect_at(14, S_CNT, 64'd1, "unused_rs_cnt");
    tick();

    // cyc 14..56: constant load-use via rt; stalls every other cycle and saturates
    clear_in();
    dwreg = 1; dm2reg = 1; drn = 3; rt = 3; use_rt = 1;
    expect_at(15, S_WPCIR, 64'd0, "rt_stall");
    expect_at(16, S_WPCIR, 64'd1, "rt_stall_released");
    expect_at(16, S_CNT, 64'd2, "rt_cnt");
    expect_at(54, S_CNT, 64'hF, "cnt_saturated");
    expect_at(56, S_CNT, 64'hF, "cnt_sat_hold");
    repeat (42) tick();

    // cyc 56 -> 57: load reaches EXE, reset asserted during the stall cycle
    tick();
    clrn = 1'b0;
    expect_at(57, S_WPCIR, 64'd0, "pre_reset_stall");
    expect_at(58, S_ALL, 64'd0, "reset_mid_stall");
    expect_at(58, S_CNT, 64'd0, "reset_mid_stall_cnt");
    expect_at(58, S_WPCIR, 64'd1, "reset_mid_stall_wpcir");
    tick();
    clrn = 1'b1;
    tick();

    // cyc 59: stall coincides with a MEM hit on rt; bubble still loaded
    mwreg = 1; mrn = 3; mm2reg = 0; malu = 32'h77;
    expect_at(59, S_WPCIR, 64'd0, "stall_vs_mem_wpcir");
    expect_at(60, S_ALL, 64'd0, "stall_vs_mem_bubble");
    expect_at(60, S_CNT, 64'd1, "stall_vs_mem_cnt");
    tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/idexe_fwd.md
# idexe_fwd

Decode-side operand stage between the register file read ports and the EXE stage. It resolves data hazards by forwarding EXE/MEM results onto the operands read from `qa`/`qb`. It detects load-use hazards and stalls fetch/decode for one cycle while inserting a bubble. It also holds the ID/EXE pipeline register that feeds the ALU.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `clrn` in 1: reset, synchronous, active-low.
- `rs`, `rt` in 5: source register numbers of the instruction in ID.
- `use_rs`, `use_rt` in 1: the instruction actually reads `rs` / `rt`.
- `qa`, `qb` in 32: register file read data for `rs` / `rt`.
- `dwreg`, `dm2reg`, `dwmem`, `daluimm` in 1: decoded controls.
- `daluc` in 4: decoded ALU control.
- `dimm` in 32: extended immediate.
- `drn` in 5: decoded destination register number.
- `ealu` in 32: current EXE ALU result, computed from this block's outputs.
- `mwreg`, `mm2reg` in 1: controls of the instruction in MEM.
- `mrn` in 5: destination register number of the instruction in MEM.
- `malu`, `mmo` in 32: MEM-stage ALU result and memory read data.
- `ewreg`, `em2reg`, `ewmem`, `ealuimm` out 1: registered controls to EXE.
- `ealuc` out 4: registered ALU control.
- `ea`, `eb`, `eimm` out 32: registered operands and immediate.
- `ern` out 5: registered destination register number.
- `wpcir` out 1: 1 = PC and IF/ID may load; 0 = stall.
- `stall_cnt` out `CNT_W`: number of stall cycles since reset.

## Operation
Forwarding (combinational), for operand A; operand B is identical with `rt`/`qb`:
- EXE hit:
  - Condition: `ewreg & ~em2reg & ern!=0 & ern==rs`.
  - Value: `ealu`.
- MEM hit:
  - Condition: `mwreg & mrn!=0 & mrn==rs`, and no EXE hit.
  - Value: `mmo` if `mm2reg`, else `malu`.
- Otherwise: `qa`.
- EXE takes priority over MEM.
- Register 0 is never forwarded.
- No WB forwarding is needed. The register file writes on the falling edge, so WB data is already present on `qa`/`qb`.

Load-use stall:
- `stall = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt))`.
- `wpcir = ~stall`.

ID/EXE register, on each rising edge:
- `clrn=0`: all registered outputs and `stall_cnt` become 0.
- `stall=1`: bubble. All E outputs are loaded with 0, so the next EXE instruction is a NOP with `ewreg=ewmem=em2reg=0`.
- Otherwise: E outputs take the `d*` controls, the forwarded A/B values, `dimm`, and `drn`.

Stall counter:
- Increments by 1 on every edge with `stall=1` and `clrn=1`.
- Saturates at all-ones and does not wrap.

## Timing
- Forwarding muxes and `wpcir` are combinational, valid in the same cycle as their inputs.
- `ea`/`eb`/E-controls have 1-cycle latency, available after the next rising edge.
- A load-use stall lasts exactly one cycle. After the bubble, `em2reg=0`, and the load reaches MEM, where it is forwarded via `mmo`.
- Reset mid-stall: the bubble is discarded, all outputs are 0, and `wpcir` returns to 1 on the next cycle (since `ewreg=0`).
- `stall` and a MEM hit in the same cycle: the stall wins and the bubble is loaded.
- `use_rs=0` or `use_rt=0` suppresses a stall on that operand. Forwarding still selects a value; the consumer ignores it.

## Test plan
- Reset: hold `clrn=0` for 2 edges with random inputs. Required: all E outputs 0, `stall_cnt=0`, `wpcir=1`.
- EXE forward:
  - Setup: E holds `ern=5`, `ewreg=1`, `em2reg=0`; `ealu=32'h1234_5678`; `rs=5`, `qa=32'hDEAD_BEEF`.
  - Required: after the edge, `ea=32'h1234_5678`.
  - Repeat with `ern=0`. Required: `ea=qa=0`.
- MEM forward, both sources:
  - Setup: `mwreg=1`, `mrn=7`, `rt=7`, `malu=32'h11`, `mmo=32'h22`.
  - Required: `eb=32'h11` when `mm2reg=0`; `eb=32'h22` when `mm2reg=1`.
  - Setup: E also matches with `ealu=32'h33`. Required: `eb=32'h33` (EXE priority).
- Load-use:
  - Setup: E holds a load (`em2reg=1`, `ern=3`); ID has `rs=3`, `use_rs=1`.
  - Required: `wpcir=0` for exactly one cycle; the next E has `ewreg=0`; `stall_cnt` increments by 1.
  - Next cycle, with `mrn=3`, `mm2reg=1`, `mmo=32'hCAFE`: required `ea=32'hCAFE` and `wpcir=1`.
  - Same case with `use_rs=0`: required no stall.
- Saturation: run with `CNT_W=4` and force 20 stall cycles. Required: `stall_cnt=4'hF` and holds.
- Reset during stall: assert `clrn=0` on the stall cycle. Required: outputs 0 and `wpcir=1` on the following cycle.
